// File: rtl/if_fetch.sv
// Instruction fetch stage: walks pc, requests imem, hands instructions to IF/ID.
// Latency: zero; a transferred word is delivered combinationally in the same cycle.
// Backpressure: imem_ready low holds pc; stall parks a transferred word in HOLD until released.
module if_fetch #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             IR_en,
  output logic [WIDTH-1:0] IR_out,
  output logic [WIDTH-1:0] PC4_out,
  output logic             flush_out,
  output logic             misalign,
  output logic [WIDTH-1:0] fetch_cnt
);

  typedef enum logic {S_REQ = 1'b0, S_HOLD = 1'b1} state_t;

  localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] hold_ir;
  logic             transfer;

  // pc is kept word aligned at every load, so the address is the pc itself
  assign imem_addr = {pc[WIDTH-1:2], 2'b00};
  assign pc_plus4  = pc + WIDTH'(4);
  assign PC4_out   = pc_plus4;
  assign flush_out = redirect;
  assign transfer  = imem_req && imem_ready;

  // State register; reset always returns to a fresh request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: redirect wins, otherwise enter HOLD on a stalled transfer and leave on release
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ:   if (transfer && stall) state_nxt = S_HOLD;
        S_HOLD:  if (!stall)            state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // Outputs: all quiet in reset; redirect kills delivery; otherwise deliver from memory or from the held word
  always_comb begin
    imem_req = 1'b0;
    IR_en    = 1'b0;
    IR_out   = '0;
    misalign = 1'b0;
    if (!rst) begin
      imem_req = (state == S_REQ);
      if (redirect) begin
        misalign = |redirect_pc[1:0];
      end else if (state == S_REQ) begin
        IR_en = imem_ready && !stall;
        if (imem_ready && !stall) IR_out = imem_rdata;
      end else begin
        IR_en = !stall;
        if (!stall) IR_out = hold_ir;
      end
    end
  end

  // Datapath registers: pc advance/redirect, capture of a stalled word, delivered-instruction count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc        <= RESET_PC_ALIGNED;
      hold_ir   <= '0;
      fetch_cnt <= '0;
    end else begin
      if (redirect) begin
        pc <= {redirect_pc[WIDTH-1:2], 2'b00};
      end else if (IR_en) begin
        pc <= pc_plus4;
      end

      if (redirect) begin
        hold_ir <= '0;
      end else if (state == S_REQ && transfer && stall) begin
        hold_ir <= imem_rdata;
      end

      if (IR_en) begin
        fetch_cnt <= fetch_cnt + WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: stimulus pushes expected deliveries into a scoreboard,
// a negedge monitor pops and compares whenever IR_en is high and checks NOP output otherwise,
// and the stimulus process checks control outputs (address, request, flush, misalign, count).
module tb_if_fetch;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic         redirect;
  logic [W-1:0] redirect_pc;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ready;
  logic [W-1:0] imem_rdata;
  logic         IR_en;
  logic [W-1:0] IR_out;
  logic [W-1:0] PC4_out;
  logic         flush_out;
  logic         misalign;
  logic [W-1:0] fetch_cnt;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc4;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  if_fetch #(.WIDTH(W), .RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .IR_en       (IR_en),
    .IR_out      (IR_out),
    .PC4_out     (PC4_out),
    .flush_out   (flush_out),
    .misalign    (misalign),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Memory returns the address as the instruction; garbage when not ready
  assign imem_rdata = imem_ready ? imem_addr : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_fetch(input logic [31:0] ir, input logic [31:0] pc4);
    sb.push_back({ir, pc4});
  endtask

  // Monitor: compare every delivery against the scoreboard, and NOP output otherwise
  always @(negedge clk) begin : monitor
    exp_t e;
    if (IR_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_delivery: got IR_out %h expected no delivery", IR_out);
      end else begin
        e = sb.pop_front();
        chk("IR_out", IR_out, e.ir);
        chk("PC4_out", PC4_out, e.pc4);
      end
    end else begin
      chk("IR_en_known", {31'b0, IR_en}, 32'h0);
      chk("IR_out_nop", IR_out, 32'h0);
    end
  end

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ready  = 1'b0;
    cyc();
    cyc();

    // Reset state
    chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst_IR_en", {31'b0, IR_en}, 32'h0);
    chk("rst_IR_out", IR_out, 32'h0);
    chk("rst_misalign", {31'b0, misalign}, 32'h0);
    chk("rst_fetch_cnt", fetch_cnt, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h3000);

    // Streaming fetch, ready every cycle
    rst = 1'b0; imem_ready = 1'b1; settle();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h3000);
    chk("first_IR_en", {31'b0, IR_en}, 32'h1);
    expect_fetch(32'h3000, 32'h3004);
    cyc(); settle();
    chk("stream_addr1", imem_addr, 32'h3004);
    expect_fetch(32'h3004, 32'h3008);
    cyc(); settle();
    expect_fetch(32'h3008, 32'h300C);
    cyc(); imem_ready = 1'b0; settle();
    chk("stream_cnt", fetch_cnt, 32'h3);
    chk("stream_idle_IR_en", {31'b0, IR_en}, 32'h0);
    chk("stream_addr3", imem_addr, 32'h300C);

    // Synchronous-style reset, then memory wait states at 0x3004
    cyc(); rst = 1'b1; settle();
    chk("rst2_cnt", fetch_cnt, 32'h0);
    chk("rst2_addr", imem_addr, 32'h3000);
    cyc(); rst = 1'b0; imem_ready = 1'b1; settle();
    expect_fetch(32'h3000, 32'h3004);
    for (int i = 0; i < 3; i++) begin
      cyc(); imem_ready = 1'b0; settle();
      chk("wait_addr", imem_addr, 32'h3004);
      chk("wait_IR_en", {31'b0, IR_en}, 32'h0);
    end
    cyc(); imem_ready = 1'b1; settle();
    chk("wait_deliver", {31'b0, IR_en}, 32'h1);
    expect_fetch(32'h3004, 32'h3008);

    // Stalled transfer of 0x3008 -> HOLD for a cycle, then release
    cyc(); stall = 1'b1; settle();
    chk("stall_addr", imem_addr, 32'h3008);
    chk("stall_IR_en", {31'b0, IR_en}, 32'h0);
    cyc(); imem_ready = 1'b0; settle();
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_IR_en", {31'b0, IR_en}, 32'h0);
    cyc(); stall = 1'b0; settle();
    chk("hold_release", {31'b0, IR_en}, 32'h1);
    expect_fetch(32'h3008, 32'h300C);
    cyc(); imem_ready = 1'b1; settle();
    chk("after_hold_addr", imem_addr, 32'h300C);
    chk("after_hold_req", {31'b0, imem_req}, 32'h1);
    expect_fetch(32'h300C, 32'h3010);

    // Redirect concurrent with transfer at 0x3010
    cyc(); redirect = 1'b1; redirect_pc = 32'h4000; settle();
    chk("redir_addr", imem_addr, 32'h3010);
    chk("redir_flush", {31'b0, flush_out}, 32'h1);
    chk("redir_IR_en", {31'b0, IR_en}, 32'h0);
    chk("redir_misalign", {31'b0, misalign}, 32'h0);
    cyc(); redirect = 1'b0; settle();
    chk("redir_target", imem_addr, 32'h4000);
    chk("redir_cnt", fetch_cnt, 32'h4);
    chk("redir_flush_off", {31'b0, flush_out}, 32'h0);
    expect_fetch(32'h4000, 32'h4004);

    // Misaligned redirect while in HOLD
    cyc(); stall = 1'b1; settle();
    chk("hold2_addr", imem_addr, 32'h4004);
    cyc(); imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h4006; settle();
    chk("mis_hold_req", {31'b0, imem_req}, 32'h0);
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_flush", {31'b0, flush_out}, 32'h1);
    chk("mis_IR_en", {31'b0, IR_en}, 32'h0);
    cyc(); redirect = 1'b0; stall = 1'b0; settle();
    chk("mis_pulse_end", {31'b0, misalign}, 32'h0);
    chk("mis_req", {31'b0, imem_req}, 32'h1);
    chk("mis_addr", imem_addr, 32'h4004);
    chk("mis_no_deliver", {31'b0, IR_en}, 32'h0);
    chk("mis_cnt", fetch_cnt, 32'h5);
    cyc(); imem_ready = 1'b1; settle();
    expect_fetch(32'h4004, 32'h4008);

    // Reset asserted between edges while in HOLD
    cyc(); stall = 1'b1; settle();
    chk("hold3_addr", imem_addr, 32'h4008);
    cyc(); imem_ready = 1'b0; settle();
    chk("hold3_req", {31'b0, imem_req}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_IR_en", {31'b0, IR_en}, 32'h0);
    chk("arst_IR_out", IR_out, 32'h0);
    chk("arst_cnt", fetch_cnt, 32'h0);
    chk("arst_addr", imem_addr, 32'h3000);
    cyc(); rst = 1'b0; stall = 1'b0; settle();
    chk("arst_rel_req", {31'b0, imem_req}, 32'h1);
    chk("arst_rel_addr", imem_addr, 32'h3000);
    chk("arst_rel_cnt", fetch_cnt, 32'h0);
    chk("arst_rel_IR_en", {31'b0, IR_en}, 32'h0);
    cyc(); imem_ready = 1'b1; settle();
    expect_fetch(32'h3000, 32'h3004);

    // pc+4 wraps at the top of the address space
    cyc(); imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; settle();
    chk("wrap_flush", {31'b0, flush_out}, 32'h1);
    cyc(); redirect = 1'b0; imem_ready = 1'b1; settle();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC, 32'h0000_0000);
    cyc(); imem_ready = 1'b0; settle();
    chk("wrap_next_addr", imem_addr, 32'h0);
    chk("wrap_cnt", fetch_cnt, 32'h2);
    chk("addr_low_bits", {30'b0, imem_addr[1:0]}, 32'h0);

    cyc();
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
